// File: rtl/data_sram_arbiter.sv
// Arbitrates the single-port data SRAM between the CPU data port (port 0) and a
// secondary DMA/debug master (port 1). The CPU has priority, and port 1 is protected from starvation.
module data_sram_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [3:0]  p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [3:0]  p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;
  logic       resp_valid;
  logic       resp_owner;
  logic       force1;

  assign force1 = p1_req && (wait_cnt == MAX_W);
  assign p1_gnt = p1_req && (force1 || !p0_req);
  assign p0_gnt = p0_req && !force1;
  assign sram_en = p0_gnt || p1_gnt;

  always_comb begin
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (p0_gnt) begin
      sram_we    = p0_we;
      sram_addr  = p0_addr;
      sram_wdata = p0_wdata;
    end else if (p1_gnt) begin
      sram_we    = p1_we;
      sram_addr  = p1_addr;
      sram_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
    end else begin
      if (p1_req && !p1_gnt) begin
        if (wait_cnt != MAX_W) wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
      resp_valid <= (p0_gnt && (p0_we == 4'b0000)) || (p1_gnt && (p1_we == 4'b0000));
      if (sram_en) resp_owner <= p1_gnt;
    end
  end

  // A response in flight when reset is asserted is suppressed in that reset cycle as well.
  assign p0_rvalid = resp_valid && !resp_owner && !reset;
  assign p1_rvalid = resp_valid &&  resp_owner && !reset;
  assign p0_rdata  = p0_rvalid ? sram_rdata : '0;
  assign p1_rdata  = p1_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Directed-vector bench for data_sram_arbiter with a behavioural write-first SRAM.
module tb_data_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p1_req;
  logic [3:0]  p0_we, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = '0;

  logic [31:0] mem [0:255];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  data_sram_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Write-first SRAM: a read issued after a write in the same slot sees the new data.
  always @(posedge clk) begin
    if (sram_en) begin
      logic [31:0] w;
      w = mem[sram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
      mem[sram_addr[9:2]] <= w;
      sram_rdata <= w;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'hDEADBEEF;   // byte address 0x100
    mem[8'h80] = 32'h12345678;   // byte address 0x200

    reset = 1'b1;
    p0_req = 1'b1; p0_we = 4'h0; p0_addr = 32'h100; p0_wdata = '0;
    p1_req = 1'b1; p1_we = 4'h0; p1_addr = 32'h200; p1_wdata = '0;
    #1;
    repeat (3) step();
    reset = 1'b0;

    // Cycle k after release: wait_cnt = k-1, so port 1 wins when k % 9 == 0.
    for (int k = 1; k <= 20; k++) begin
      logic exp_p1, prev_p1;
      exp_p1  = (k % 9 == 0);
      prev_p1 = ((k - 1) % 9 == 0) && (k > 1);
      sample();
      check($sformatf("cont_p0_gnt_%0d", k), 32'(p0_gnt), 32'(!exp_p1));
      check($sformatf("cont_p1_gnt_%0d", k), 32'(p1_gnt), 32'(exp_p1));
      if (k == 1) begin
        check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
      end else begin
        check($sformatf("cont_p1_rvalid_%0d", k), 32'(p1_rvalid), 32'(prev_p1));
        check($sformatf("cont_p0_rdata_%0d", k), p0_rdata, prev_p1 ? 32'h0 : 32'hDEADBEEF);
        check($sformatf("cont_p1_rdata_%0d", k), p1_rdata, prev_p1 ? 32'h12345678 : 32'h0);
      end
      step();
    end

    p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) step();

    // CPU read alone
    p0_req = 1'b1; p0_we = 4'h0; p0_addr = 32'h100;
    sample();
    check("rd_p0_gnt", 32'(p0_gnt), 32'd1);
    check("rd_p1_gnt", 32'(p1_gnt), 32'd0);
    check("rd_sram_en", 32'(sram_en), 32'd1);
    check("rd_sram_addr", sram_addr, 32'h100);
    step();
    p0_req = 1'b0;
    sample();
    check("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
    check("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
    check("rd_p1_rvalid", 32'(p1_rvalid), 32'd0);
    step();

    // Write by port 0, then read of the same address by port 1
    p0_req = 1'b1; p0_we = 4'hF; p0_addr = 32'h20; p0_wdata = 32'h55AA00FF;
    sample();
    check("wr_p0_gnt", 32'(p0_gnt), 32'd1);
    check("wr_sram_we", 32'(sram_we), 32'hF);
    check("wr_sram_wdata", sram_wdata, 32'h55AA00FF);
    step();
    p0_req = 1'b0; p0_we = 4'h0;
    p1_req = 1'b1; p1_we = 4'h0; p1_addr = 32'h20;
    sample();
    check("il_p1_gnt", 32'(p1_gnt), 32'd1);
    check("il_sram_addr", sram_addr, 32'h20);
    check("il_p0_rvalid_wr", 32'(p0_rvalid), 32'd0);
    check("il_p1_rvalid_wr", 32'(p1_rvalid), 32'd0);
    step();
    p1_req = 1'b0;
    sample();
    check("il_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("il_p1_rdata", p1_rdata, 32'h55AA00FF);
    check("il_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("idle_sram_en", 32'(sram_en), 32'd0);
    check("idle_sram_addr", sram_addr, 32'h0);
    step();

    // Withdraw: p1 waits 5 cycles, drops for one, then needs 8 more waits.
    p0_req = 1'b1; p0_addr = 32'h100;
    p1_addr = 32'h200;
    for (int k = 1; k <= 15; k++) begin
      p1_req = (k != 6);
      sample();
      check($sformatf("wd_p1_gnt_%0d", k), 32'(p1_gnt), 32'(k == 15));
      check($sformatf("wd_p0_gnt_%0d", k), 32'(p0_gnt), 32'(k != 15));
      step();
    end
    p0_req = 1'b0;
    sample();
    check("wd_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("wd_p1_rdata", p1_rdata, 32'h12345678);
    p1_req = 1'b0;
    step();
    step();

    // Reset with a port 1 read in flight
    p1_req = 1'b1; p1_addr = 32'h200;
    sample();
    check("rm_p1_gnt", 32'(p1_gnt), 32'd1);
    step();
    p1_req = 1'b0; reset = 1'b1;
    sample();
    check("rm_p1_rvalid_n1", 32'(p1_rvalid), 32'd0);
    check("rm_p1_rdata_n1", p1_rdata, 32'h0);
    step();
    reset = 1'b0;
    sample();
    check("rm_p1_rvalid_n2", 32'(p1_rvalid), 32'd0);
    check("rm_p0_rvalid_n2", 32'(p0_rvalid), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/data_sram_arbiter.md
# data_sram_arbiter

Shares the single-port synchronous data SRAM between two masters: the CPU pipeline data port (port 0, issued from EXE with the read result consumed in MEM) and a secondary master (port 1, DMA/debug loader). Per-port request/grant handshake, fixed priority to the CPU with a starvation guard for port 1, and read-response routing back to the owning port one cycle after grant. Sits between the pipeline memory ports and the data SRAM macro.

## Interface
- MAX_WAIT, 8: cycles port 1 may be held off (request asserted, not granted) before it is forced to win; range 1..255.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  CPU access request.
- p0_we  in  4  CPU byte write enables; 4'b0000 = read.
- p0_addr  in  32  CPU byte address.
- p0_wdata  in  32  CPU write data.
- p0_gnt  out  1  CPU request accepted this cycle.
- p0_rvalid  out  1  CPU read data valid.
- p0_rdata  out  32  CPU read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same widths and meanings for port 1.
- sram_en  out  1  SRAM access enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM byte address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after an enabled read.

## Operation
- Transfer on port k occurs in a cycle where pk_req && pk_gnt. At most one gnt per cycle.
- Grant (combinational from current req and registered state):
  - force1 = p1_req && (wait_cnt == MAX_WAIT).
  - p1_gnt = p1_req && (force1 || !p0_req).
  - p0_gnt = p0_req && !force1.
- SRAM drive: sram_en = p0_gnt || p1_gnt; sram_we/addr/wdata muxed from granted port; when no grant, sram_we = 0, addr/wdata = 0.
- Starvation counter wait_cnt (8-bit, saturating at MAX_WAIT):
  - p1_req && !p1_gnt: increment (hold at MAX_WAIT).
  - p1_gnt or !p1_req: clear to 0.
- Response tracker (registered): resp_valid <= granted access is a read (we == 0); resp_owner <= index of granted port. Writes produce no response.
- pk_rvalid = resp_valid && (resp_owner == k). pk_rdata = sram_rdata when pk_rvalid, else 32'h0.
- Responses are unconditional; requesters must accept rvalid in the cycle it is asserted (CPU MEM stage consumes it without stall).
- Requesters must hold req/we/addr/wdata stable until granted.

## Timing
- Reset values: resp_valid 0, resp_owner 0, wait_cnt 0; hence p0_rvalid = p1_rvalid = 0 and p0_rdata = p1_rdata = 0 after reset. gnt and sram_* are combinational; sram_en follows requests in the first cycle after reset.
- Grant latency 0 cycles (same cycle as req when winning); read latency: grant in cycle N -> rvalid/rdata in N+1.
- Back-to-back grants every cycle supported, any mix of ports and reads/writes; response pipeline never blocks a grant.
- Simultaneous p0_req and p1_req: p0 wins unless wait_cnt == MAX_WAIT, then p1 wins exactly once and wait_cnt clears.
- Port 1 worst-case wait under continuous p0 traffic: MAX_WAIT cycles, granted in cycle MAX_WAIT+1 of its request.
- p1_req dropped before grant: wait_cnt clears; no forced grant retained.
- Reset asserted with a read in flight: resp_valid cleared, the response is discarded (no rvalid the cycle after reset).
- Write in cycle N followed by read of same address in N+1: read returns the written data (SRAM write-first ordering is relied upon; arbiter adds no reordering).

## Test plan
- Reset: hold reset 3 cycles with both reqs high -> p0_rvalid = p1_rvalid = 0, rdata = 0, wait_cnt = 0 after release.
- CPU read alone: p0 read addr 0x100, SRAM returns 0xDEADBEEF -> p0_gnt in N, p0_rvalid=1 with 0xDEADBEEF in N+1, p1_rvalid=0.
- Contention: p0 and p1 read continuously, MAX_WAIT=8 -> p0 granted 8 cycles, p1 granted in 9th, p0 resumes in 10th; pattern repeats.
- Interleaved: p0 write 0x55AA00FF to 0x20 (we=4'hF) in N, p1 read 0x20 in N+1 -> p1_rvalid in N+2 with 0x55AA00FF; no rvalid for the write.
- Withdraw: p1_req high 5 cycles under p0 traffic then low 1 cycle then high -> wait_cnt restarts at 0; forced grant only after 8 further wait cycles.
- Reset mid-read: p1 read granted in N, reset in N+1 -> p1_rvalid stays 0 in N+1 and N+2.
